fifo_control: RTL and testbench
===============================

Name: fifo_control

Overview:
- Pointer, flag and handshake controller for the externally addressed FIFO memory (data_width 10, 3-bit wr_ptr/rd_ptr).
- Turns requester push/pop into the memory's wr_enable, rd_enable, wr_ptr and rd_ptr.
- Tracks occupancy; produces full/empty, programmable almost-full/almost-empty and sticky error flags.
- Sits between the FIFO memory and the upstream/downstream logic; the memory holds data only.

Parameters:
address_width, 3, pointer width; depth = 2**address_width (8 entries)

Ports:
clk  input  1  single clock, all state on posedge
reset  input  1  synchronous, active-high; clears all state
push  input  1  write request; memory captures FIFO_data_in this cycle if accepted
pop  input  1  read request
afull_thresh  input  address_width+1  almost_full level
aempty_thresh  input  address_width+1  almost_empty level
wr_enable  output  1  to memory, write strobe
rd_enable  output  1  to memory, read strobe
wr_ptr  output  address_width  to memory, write address
rd_ptr  output  address_width  to memory, read address
full  output  1  count == depth
empty  output  1  count == 0
almost_full  output  1  count >= afull_thresh
almost_empty  output  1  count <= aempty_thresh
fifo_count  output  address_width+1  current occupancy, 0..depth
data_valid  output  1  memory FIFO_data_out holds popped word this cycle
overflow_err  output  1  sticky, push rejected while full
underflow_err  output  1  sticky, pop rejected while empty

Behaviour:
- Registered state: wr_ptr, rd_ptr, fifo_count, data_valid, overflow_err, underflow_err.
- Reset (reset=1 at posedge): all registered state 0. Resulting outputs: empty=1, full=0, almost_full=(afull_thresh==0), almost_empty=1. Reset overrides push/pop in the same cycle; an in-flight data_valid is dropped.
- Acceptance (combinational from current state):
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok). Push on full with a simultaneous accepted pop is allowed.
- Memory strobes: wr_enable = push_ok, rd_enable = pop_ok, combinational. Memory acts at the same posedge using the current wr_ptr/rd_ptr.
- Pointer update at posedge:
  - wr_ptr += push_ok; rd_ptr += pop_ok.
  - Modulo depth; 7 -> 0 wraps naturally.
- Count update: push_ok & ~pop_ok: +1; pop_ok & ~push_ok: -1; both or neither: unchanged.
- Read latency: 1 cycle. data_valid <= pop_ok, so data_valid is high the cycle after rd_enable, aligned with the memory's registered data_out.
- Flags: full, empty, almost_full and almost_empty are combinational from registered fifo_count only, never from push/pop. Thresholds are compared unsigned and may change at any time; flags follow immediately.
- Errors:
  - overflow_err <= 1 when push & full & ~pop_ok.
  - underflow_err <= 1 when pop & empty. Push+pop on empty: push accepted, pop rejected, underflow_err set.
  - Both errors cleared only by reset.
- Rejected requests: no pointer/count change, no memory strobe.
- Invariant: fifo_count == (wr_ptr - rd_ptr) mod depth, except count == depth when the pointers are equal and full.

Decomposition:
- No shared package needed.
- Local derived constant DEPTH = 1 << address_width.
- One natural sub-module, fifo_ptr_cnt: an address_width-bit wrapping counter with synchronous reset and inc enable. Instantiate twice, for the write and read pointers.
- Count, flags and error logic stay in fifo_control.

Test Plan:
- Reset then idle: assert reset 2 cycles, release -> wr_ptr=0, rd_ptr=0, fifo_count=0, empty=1, full=0, errors=0, data_valid=0.
- Fill: 8 consecutive pushes, afull_thresh=6 -> wr_enable high 8 cycles, wr_ptr 0..7 then 0. almost_full rises after the 6th push, full=1 and fifo_count=8 after the 8th. A 9th push gives wr_enable=0, overflow_err=1, wr_ptr stays 0.
- Drain: from full, 9 pops, aempty_thresh=2 -> rd_ptr 0..7 then 0. data_valid high one cycle after each accepted rd_enable, and the words match the write order. almost_empty=1 once count<=2, empty=1 at count 0. The 9th pop gives rd_enable=0, underflow_err=1.
- Simultaneous push+pop:
  - At count 3: both pointers advance, count stays 3.
  - At full (8): push accepted, count stays 8, no overflow_err.
  - At empty: only push accepted, count=1, underflow_err=1.
- Wrap-around: 5 pushes, 5 pops, then 6 pushes -> wr_ptr goes 5,6,7,0,1,2 and lands on 3. fifo_count=6, data read back in order across the wrap.
- Reset mid-operation: at count 4 with a pop in flight, assert reset -> next cycle pointers=0, count=0, data_valid=0, errors cleared, empty=1.

Source files
------------

// File: rtl/fifo_ptr_cnt.sv
// fifo_ptr_cnt
//   Wrapping address counter used for the FIFO write and read pointers.
//   The pointer advances by one on every cycle where inc_i is high and
//   wraps from 2**Width-1 back to 0 through plain modulo arithmetic.
//
// Ports
//   clk    : single clock, all state on posedge
//   reset  : synchronous, active-high; returns the pointer to 0
//   inc_i  : advance the pointer at the next posedge
//   ptr_o  : current pointer value
module fifo_ptr_cnt #(
  parameter int Width = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [Width-1:0] ptr_o
);

  localparam logic [Width-1:0] PtrOne = Width'(1);

  logic [Width-1:0] ptr_q;
  logic [Width-1:0] ptr_d;

  // Next pointer value; the natural overflow of the adder gives the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + PtrOne;
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_control.sv
// fifo_control
//   Pointer, flag and handshake controller for an externally addressed
//   FIFO memory. Converts push/pop requests into memory write/read strobes
//   and addresses, tracks occupancy, and produces full/empty, programmable
//   almost-full/almost-empty, read-data-valid and sticky error flags.
//
// Ports
//   clk, reset      : clock and synchronous active-high reset
//   push, pop       : requester write/read requests
//   afull_thresh    : almost_full when fifo_count >= this level
//   aempty_thresh   : almost_empty when fifo_count <= this level
//   wr_enable/wr_ptr: write strobe and address to the memory
//   rd_enable/rd_ptr: read strobe and address to the memory
//   full, empty     : occupancy at depth / at zero
//   almost_full/almost_empty : threshold flags
//   fifo_count      : occupancy, 0..depth
//   data_valid      : memory data_out holds the popped word this cycle
//   overflow_err    : sticky, push rejected while full
//   underflow_err   : sticky, pop rejected while empty
module fifo_control #(
  parameter int address_width = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [address_width:0]   afull_thresh,
  input  logic [address_width:0]   aempty_thresh,
  output logic                     wr_enable,
  output logic                     rd_enable,
  output logic [address_width-1:0] wr_ptr,
  output logic [address_width-1:0] rd_ptr,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [address_width:0]   fifo_count,
  output logic                     data_valid,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int unsigned DEPTH = 1 << address_width;
  localparam logic [address_width:0] DepthCount = (address_width + 1)'(DEPTH);
  localparam logic [address_width:0] CountOne   = (address_width + 1)'(1);

  logic [address_width:0] count_q;
  logic [address_width:0] count_d;
  logic                   dataValid_q;
  logic                   overflowErr_q;
  logic                   underflowErr_q;
  logic                   overflowErr_d;
  logic                   underflowErr_d;
  logic                   pushOk;
  logic                   popOk;

  // Flags come from the registered count only so they never glitch with
  // the requests of the current cycle.
  assign full         = (count_q == DepthCount);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= afull_thresh);
  assign almost_empty = (count_q <= aempty_thresh);

  // A push on a full FIFO is still accepted when a pop frees a slot in the
  // same cycle; a pop on an empty FIFO is never accepted.
  assign popOk  = pop & ~empty;
  assign pushOk = push & (~full | popOk);

  assign wr_enable = pushOk;
  assign rd_enable = popOk;

  fifo_ptr_cnt #(.Width(address_width)) uWrPtr (
    .clk   (clk),
    .reset (reset),
    .inc_i (pushOk),
    .ptr_o (wr_ptr)
  );

  fifo_ptr_cnt #(.Width(address_width)) uRdPtr (
    .clk   (clk),
    .reset (reset),
    .inc_i (popOk),
    .ptr_o (rd_ptr)
  );

  // Occupancy and sticky error next-state. Simultaneous accepted push and
  // pop leave the count unchanged.
  always_comb begin
    count_d        = count_q;
    overflowErr_d  = overflowErr_q;
    underflowErr_d = underflowErr_q;
    if (pushOk && !popOk) begin
      count_d = count_q + CountOne;
    end else if (popOk && !pushOk) begin
      count_d = count_q - CountOne;
    end
    if (push && full && !popOk) begin
      overflowErr_d = 1'b1;
    end
    if (pop && empty) begin
      underflowErr_d = 1'b1;
    end
  end

  // Registered state; data_valid trails rd_enable by one cycle to line up
  // with the memory's registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q        <= '0;
      dataValid_q    <= 1'b0;
      overflowErr_q  <= 1'b0;
      underflowErr_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      dataValid_q    <= popOk;
      overflowErr_q  <= overflowErr_d;
      underflowErr_q <= underflowErr_d;
    end
  end

  assign fifo_count    = count_q;
  assign data_valid    = dataValid_q;
  assign overflow_err  = overflowErr_q;
  assign underflow_err = underflowErr_q;

endmodule

// File: tb/tb_fifo_control.sv
// tb_fifo_control
//   Self-checking bench for fifo_control. A small behavioural memory is
//   attached to the strobes/addresses, and a queue-based reference model
//   predicts every output each cycle from push/pop/reset stimulus.
module tb_fifo_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic       pop;
  logic [3:0] afullThresh;
  logic [3:0] aemptyThresh;
  logic       wrEnable;
  logic       rdEnable;
  logic [2:0] wrPtr;
  logic [2:0] rdPtr;
  logic       full;
  logic       empty;
  logic       almostFull;
  logic       almostEmpty;
  logic [3:0] fifoCount;
  logic       dataValid;
  logic       overflowErr;
  logic       underflowErr;

  logic [9:0] dataIn;
  logic [9:0] dataOut;
  logic [9:0] mem [8];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [9:0] modelQ [$];
  int         modelWp;
  int         modelRp;
  bit         modelOvf;
  bit         modelUnf;
  bit         modelDv;
  logic [9:0] modelData;

  fifo_control #(.address_width(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .pop           (pop),
    .afull_thresh  (afullThresh),
    .aempty_thresh (aemptyThresh),
    .wr_enable     (wrEnable),
    .rd_enable     (rdEnable),
    .wr_ptr        (wrPtr),
    .rd_ptr        (rdPtr),
    .full          (full),
    .empty         (empty),
    .almost_full   (almostFull),
    .almost_empty  (almostEmpty),
    .fifo_count    (fifoCount),
    .data_valid    (dataValid),
    .overflow_err  (overflowErr),
    .underflow_err (underflowErr)
  );

  always #5 clk = ~clk;

  // Memory attached to the controller: data only, registered read port.
  always @(posedge clk) begin
    if (wrEnable) mem[wrPtr] <= dataIn;
    if (rdEnable) dataOut <= mem[rdPtr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, check all outputs against the
  // model, then advance the model at the posedge.
  task automatic applyStimulus(input bit rst, input bit ps, input bit pp);
    int  cnt;
    bit  popOk;
    bit  pushOk;
    @(negedge clk);
    reset  = rst;
    push   = ps;
    pop    = pp;
    dataIn = 10'($urandom);
    #1;
    cnt    = modelQ.size();
    popOk  = pp && (cnt > 0);
    pushOk = ps && ((cnt < 8) || popOk);
    checkOutput("count",        32'(fifoCount),    32'(cnt));
    checkOutput("empty",        32'(empty),        32'(cnt == 0));
    checkOutput("full",         32'(full),         32'(cnt == 8));
    checkOutput("almost_full",  32'(almostFull),   32'(cnt >= int'(afullThresh)));
    checkOutput("almost_empty", 32'(almostEmpty),  32'(cnt <= int'(aemptyThresh)));
    checkOutput("wr_ptr",       32'(wrPtr),        32'(modelWp));
    checkOutput("rd_ptr",       32'(rdPtr),        32'(modelRp));
    checkOutput("wr_enable",    32'(wrEnable),     32'(pushOk));
    checkOutput("rd_enable",    32'(rdEnable),     32'(popOk));
    checkOutput("data_valid",   32'(dataValid),    32'(modelDv));
    checkOutput("overflow",     32'(overflowErr),  32'(modelOvf));
    checkOutput("underflow",    32'(underflowErr), 32'(modelUnf));
    if (modelDv) checkOutput("read_data", 32'(dataOut), 32'(modelData));
    @(posedge clk);
    if (rst) begin
      modelQ.delete();
      modelWp  = 0;
      modelRp  = 0;
      modelOvf = 0;
      modelUnf = 0;
      modelDv  = 0;
    end else begin
      if (ps && !pushOk) modelOvf = 1;
      if (pp && cnt == 0) modelUnf = 1;
      modelDv = popOk;
      if (popOk) begin
        modelData = modelQ.pop_front();
        modelRp   = (modelRp + 1) % 8;
      end
      if (pushOk) begin
        modelQ.push_back(dataIn);
        modelWp = (modelWp + 1) % 8;
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    push         = 1'b0;
    pop          = 1'b0;
    dataIn       = '0;
    afullThresh  = 4'd6;
    aemptyThresh = 4'd2;
    modelWp = 0; modelRp = 0; modelOvf = 0; modelUnf = 0; modelDv = 0;
    modelData = '0;
    repeat (2) @(posedge clk);

    // Reset state, then fill past full
    applyStimulus(0, 0, 0);
    repeat (9) applyStimulus(0, 1, 0);
    // Drain past empty
    repeat (9) applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);

    // Simultaneous push+pop at empty, at 3, and at full
    applyStimulus(0, 1, 1);
    repeat (2) applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    repeat (5) applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 0);

    // Wrap-around from a clean reset
    applyStimulus(1, 0, 0);
    repeat (5) applyStimulus(0, 1, 0);
    repeat (5) applyStimulus(0, 0, 1);
    repeat (6) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);

    // Reset while a pop is in flight at count 4
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);

    // Randomized traffic with moving thresholds and occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        afullThresh  = 4'($urandom_range(0, 9));
        aemptyThresh = 4'($urandom_range(0, 9));
      end
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1);
    end
    applyStimulus(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
